// File: rtl/debug_unit_pkg.sv
// Shared definitions for the host debug unit: command bytes, FSM encoding and
// the layout of the PC / register / memory dump.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC000000;

  localparam int DUMP_PC_WORDS  = 1;
  localparam int DUMP_REG_WORDS = 32;
  localparam int DUMP_MEM_WORDS = 32;
  localparam int DUMP_WORDS     = DUMP_PC_WORDS + DUMP_REG_WORDS + DUMP_MEM_WORDS;
  localparam int WORD_IDX_W     = $clog2(DUMP_WORDS);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_WRITE   = 4'd2,
    ST_RUN     = 4'd3,
    ST_STEP    = 4'd4,
    ST_SETTLE  = 4'd5,
    ST_LATCH   = 4'd6,
    ST_TX_BYTE = 4'd7,
    ST_TX_WAIT = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_SEND = 2'd1,
    SER_WAIT = 2'd2
  } ser_phase_e;

  // Word 0 is the PC; words 1..32 map to registers 0..31 and 33..64 to memory
  // words 0..31, so both sections reduce to (idx - 1) modulo 32.
  function automatic logic [4:0] dump_addr(input logic [WORD_IDX_W-1:0] idx);
    return 5'(idx - WORD_IDX_W'(1));
  endfunction

endpackage

// File: rtl/debug_unit_word_tx_serializer.sv
// Loads one word and sends it MSB-first as NBYTES bytes over a
// start-strobe / done-strobe UART TX handshake.
module word_tx_serializer
  import debug_unit_pkg::*;
#(
  parameter int BYTE_SZ = 8,
  parameter int NBYTES  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [BYTE_SZ*NBYTES-1:0] i_word,
  input  logic                      i_tx_done,
  output logic [BYTE_SZ-1:0]        o_tx_data,
  output logic                      o_tx_start,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int W     = BYTE_SZ * NBYTES;
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  ser_phase_e       phase_q, phase_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_d = phase_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    o_done  = 1'b0;
    case (phase_q)
      SER_IDLE: if (i_start) begin
        shift_d = i_word;
        cnt_d   = '0;
        phase_d = SER_SEND;
      end
      SER_SEND: phase_d = SER_WAIT;
      SER_WAIT: if (i_tx_done) begin
        if (cnt_q == LAST_BYTE) begin
          o_done  = 1'b1;
          phase_d = SER_IDLE;
        end else begin
          shift_d = {shift_q[W-BYTE_SZ-1:0], {BYTE_SZ{1'b0}}};
          cnt_d   = cnt_q + 1'b1;
          phase_d = SER_SEND;
        end
      end
      default: phase_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      phase_q <= SER_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Top byte of the shift register is held steady until its done strobe.
  assign o_tx_data  = shift_q[W-1 -: BYTE_SZ];
  assign o_tx_start = (phase_q == SER_SEND);
  assign o_busy     = (phase_q != SER_IDLE);

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline: loads a program from UART,
// runs or steps it, then streams PC, register file and data memory back.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int                 INST_SZ     = 32,
  parameter int                 PC_SZ       = 32,
  parameter int                 REG_SZ      = 5,
  parameter int                 BYTE_SZ     = 8,
  parameter logic [INST_SZ-1:0] HALT_INSTR  = HALT_INSTR_DEFAULT,
  parameter int                 INST_MAX    = 256,
  parameter int                 RUN_TIMEOUT = 1 << 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic               i_halt,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  output logic [3:0]         o_state
);

  localparam int NBYTES = INST_SZ / BYTE_SZ;
  localparam int BCNT_W = $clog2(NBYTES);
  localparam int LCNT_W = $clog2(INST_MAX + 1);
  localparam int TCNT_W = $clog2(RUN_TIMEOUT);

  localparam logic [BCNT_W-1:0]     LAST_BYTE    = BCNT_W'(NBYTES - 1);
  localparam logic [LCNT_W-1:0]     INST_MAX_C   = LCNT_W'(INST_MAX);
  localparam logic [TCNT_W-1:0]     TIMEOUT_LAST = TCNT_W'(RUN_TIMEOUT - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD    = WORD_IDX_W'(DUMP_WORDS - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_REG_IDX = WORD_IDX_W'(DUMP_REG_WORDS);

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [INST_SZ-1:0]    word_q, word_d;
  logic [LCNT_W-1:0]     load_cnt_q, load_cnt_d;
  logic [TCNT_W-1:0]     timer_q, timer_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic [INST_SZ-1:0]    instr_q, instr_d;
  logic                  write_q, write_d;
  logic                  enable_q, enable_d;
  logic [REG_SZ-1:0]     addr_q, addr_d;

  logic [INST_SZ-1:0] word_next;
  logic [INST_SZ-1:0] ser_word;
  logic               ser_start;
  logic               ser_busy;
  logic               ser_done;

  assign word_next = {word_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};

  always_comb begin
    if (word_idx_q == '0)              ser_word = INST_SZ'(i_pc);
    else if (word_idx_q <= LAST_REG_IDX) ser_word = i_reg;
    else                               ser_word = i_mem;
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    load_cnt_d = load_cnt_q;
    timer_d    = timer_q;
    word_idx_d = word_idx_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    write_d    = 1'b0;
    enable_d   = 1'b0;
    ser_start  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_LOAD: begin
            state_d    = ST_LOAD;
            byte_cnt_d = '0;
            load_cnt_d = '0;
          end
          CMD_RUN: begin
            state_d  = ST_RUN;
            enable_d = 1'b1;
            timer_d  = '0;
          end
          CMD_STEP: begin
            state_d  = ST_STEP;
            enable_d = !i_halt;
          end
          default: ;
        endcase
      end
      ST_LOAD: if (i_rx_valid) begin
        word_d = word_next;
        if (byte_cnt_q == LAST_BYTE) begin
          state_d    = ST_WRITE;
          byte_cnt_d = '0;
          instr_d    = word_next;
          // Words past the capacity are still parsed so the halt word is found.
          if (load_cnt_q < INST_MAX_C) begin
            write_d    = 1'b1;
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      ST_WRITE: state_d = (word_q == HALT_INSTR) ? ST_IDLE : ST_LOAD;
      ST_RUN: begin
        timer_d = timer_q + 1'b1;
        if (i_halt || timer_q == TIMEOUT_LAST) begin
          state_d    = ST_SETTLE;
          word_idx_d = '0;
          addr_d     = '0;
        end else begin
          enable_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d    = ST_SETTLE;
        word_idx_d = '0;
        addr_d     = '0;
      end
      ST_SETTLE: state_d = ST_LATCH;
      ST_LATCH: begin
        ser_start = 1'b1;
        state_d   = ST_TX_BYTE;
      end
      ST_TX_BYTE: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (ser_done) begin
          if (word_idx_q == LAST_WORD) begin
            state_d = ST_IDLE;
            addr_d  = '0;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
            addr_d     = REG_SZ'(dump_addr(word_idx_q + 1'b1));
            state_d    = ST_SETTLE;
          end
        end else if (i_tx_done && ser_busy) begin
          state_d = ST_TX_BYTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      load_cnt_q <= '0;
      timer_q    <= '0;
      word_idx_q <= '0;
      instr_q    <= '0;
      write_q    <= 1'b0;
      enable_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      load_cnt_q <= load_cnt_d;
      timer_q    <= timer_d;
      word_idx_q <= word_idx_d;
      instr_q    <= instr_d;
      write_q    <= write_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
    end
  end

  word_tx_serializer #(
    .BYTE_SZ (BYTE_SZ),
    .NBYTES  (NBYTES)
  ) u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (ser_start),
    .i_word     (ser_word),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (ser_busy),
    .o_done     (ser_done)
  );

  assign o_instruction = instr_q;
  assign o_write       = write_q;
  assign o_enable      = enable_q;
  assign o_debug_addr  = addr_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: command table plus load / run / step /
// dump sequences, with queued expectations for TX bytes and instruction writes.
module tb_debug_unit;

  localparam int          INST_MAX    = 4;
  localparam int          RUN_TIMEOUT = 100;
  localparam logic [31:0] HALT        = 32'hFC000000;
  localparam logic [7:0]  C_L = 8'h4C, C_C = 8'h43, C_S = 8'h53;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, tx_done = 1'b0, halt = 1'b0;
  logic [31:0] pc = 32'h0, reg_val = 32'h0, mem_val = 32'h0;
  logic        addr_mix = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start, wr, en;
  logic [31:0] instr, reg_w, mem_w;
  logic [4:0]  daddr;
  logic [3:0]  st;

  // Pipeline model: register/memory words optionally depend on the debug address.
  assign reg_w = addr_mix ? (reg_val ^ {27'd0, daddr}) : reg_val;
  assign mem_w = addr_mix ? (mem_val ^ {daddr, 27'd0}) : mem_val;

  int          errors = 0, checks = 0, en_total = 0;
  logic [7:0]  exp_tx[$], got_tx[$];
  logic [31:0] exp_wr[$], got_wr[$];

  typedef struct {
    logic [7:0]  rx;
    logic        halt;
    logic [3:0]  exp_state;
    logic        exp_en;
    logic [31:0] pc, reg_v, mem_v;
    logic        mix;
  } vec_t;
  vec_t vec[5];

  always #5 clk = ~clk;

  debug_unit #(.INST_MAX(INST_MAX), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_pc(pc), .i_mem(mem_w), .i_reg(reg_w), .i_halt(halt),
    .o_instruction(instr), .o_write(wr), .o_enable(en),
    .o_debug_addr(daddr), .o_state(st)
  );

  // UART TX responder: records each byte, then returns a done strobe.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      got_tx.push_back(tx_data);
      repeat (2) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (wr) got_wr.push_back(instr);
    if (en) en_total++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    $display("rx byte %h -> state %0d", b, st);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] p, input logic [31:0] r, input logic [31:0] m, input logic mix);
    push_word(p);
    for (int a = 0; a < 32; a++) push_word(mix ? (r ^ 32'(a)) : r);
    for (int a = 0; a < 32; a++) push_word(mix ? (m ^ (32'(a) << 27)) : m);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (st != 4'd0 && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " back to idle"}, 32'(st), 32'd0);
  endtask

  task automatic check_dump(input string name);
    logic [7:0] g, e;
    int i;
    check({name, " dump length"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    i = 0;
    while (exp_tx.size() > 0 && got_tx.size() > 0) begin
      g = got_tx.pop_front();
      e = exp_tx.pop_front();
      check($sformatf("%s dump byte %0d", name, i), 32'(g), 32'(e));
      i++;
    end
    $display("dump %s: %0d bytes compared", name, i);
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic check_writes(input string name);
    logic [31:0] g, e;
    check({name, " write count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    while (exp_wr.size() > 0 && got_wr.size() > 0) begin
      g = got_wr.pop_front();
      e = exp_wr.pop_front();
      check({name, " write word"}, g, e);
      $display("write %s: %h", name, g);
    end
    got_wr.delete();
    exp_wr.delete();
  endtask

  initial begin
    int base, n;
    vec[0] = '{8'h58, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    vec[1] = '{8'h6C, 1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    vec[2] = '{C_L,   1'b0, 4'd1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    vec[3] = '{C_S,   1'b0, 4'd4, 1'b1, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0};
    vec[4] = '{C_S,   1'b1, 4'd4, 1'b0, 32'h8, 32'h11223344, 32'hA5A5A5A5, 1'b1};

    repeat (3) @(posedge clk); #1;
    check("reset state", 32'(st), 32'd0);
    check("reset write", 32'(wr), 32'd0);
    check("reset enable", 32'(en), 32'd0);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset debug_addr", 32'(daddr), 32'd0);
    check("reset instruction", instr, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      halt = vec[i].halt; pc = vec[i].pc; reg_val = vec[i].reg_v;
      mem_val = vec[i].mem_v; addr_mix = vec[i].mix;
      if (vec[i].exp_state == 4'd4) push_dump(pc, reg_val, mem_val, addr_mix);
      base = en_total;
      send_byte(vec[i].rx);
      @(negedge clk);
      check($sformatf("vec%0d state", i), 32'(st), 32'(vec[i].exp_state));
      check($sformatf("vec%0d enable", i), 32'(en), 32'(vec[i].exp_en));
      if (vec[i].exp_state == 4'd1) begin
        exp_wr.push_back(HALT);
        send_word(HALT);
        repeat (3) @(posedge clk); #1;
        check($sformatf("vec%0d state after halt word", i), 32'(st), 32'd0);
        check_writes($sformatf("vec%0d", i));
      end else if (vec[i].exp_state == 4'd4) begin
        wait_idle($sformatf("vec%0d", i));
        check_dump($sformatf("vec%0d", i));
        check($sformatf("vec%0d enable cycles", i), 32'(en_total - base), 32'(vec[i].exp_en));
        check($sformatf("vec%0d final debug_addr", i), 32'(daddr), 32'd0);
      end
    end
    halt = 1'b0;

    // Reset in the middle of a load discards the partial word.
    send_byte(C_L); send_byte(8'h20); send_byte(8'h01);
    #3 rst_n = 1'b0;
    #1;
    check("async reset mid-load state", 32'(st), 32'd0);
    check("async reset mid-load write", 32'(wr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_wr.push_back(32'h20010005);
    exp_wr.push_back(HALT);
    send_byte(C_L);
    send_word(32'h20010005);
    send_word(HALT);
    repeat (3) @(posedge clk); #1;
    check("reload state", 32'(st), 32'd0);
    check_writes("reload");

    // Continuous run, halt raised after 50 enabled cycles.
    pc = 32'h00000123; reg_val = 32'h0BADF00D; mem_val = 32'h5A5A0000; addr_mix = 1'b1;
    push_dump(pc, reg_val, mem_val, 1'b1);
    base = en_total;
    send_byte(C_C);
    n = 0;
    while (en_total - base < 50 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    halt = 1'b1;
    wait_idle("run-halt");
    check("run-halt enable cycles", 32'(en_total - base), 32'd51);
    check_dump("run-halt");
    halt = 1'b0;

    // Continuous run without halt: timeout, with commands sent mid-dump.
    pc = 32'hCAFE0010; reg_val = 32'h01020304; mem_val = 32'hFFFF0000;
    push_dump(pc, reg_val, mem_val, 1'b1);
    base = en_total;
    send_byte(C_C);
    n = 0;
    while (got_tx.size() < 100 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    send_byte(C_L);
    check("L during dump keeps dump state", 32'(st >= 4'd5), 32'd1);
    send_byte(8'h58);
    check("X during dump keeps dump state", 32'(st >= 4'd5), 32'd1);
    wait_idle("timeout");
    check("timeout enable cycles", 32'(en_total - base), 32'(RUN_TIMEOUT));
    check_dump("timeout");
    check_writes("timeout");

    // Over-capacity load: only INST_MAX words are written, halt word still ends it.
    send_byte(C_L);
    for (int w = 0; w < INST_MAX + 3; w++) begin
      if (w < INST_MAX) exp_wr.push_back(32'h20000000 + 32'(w));
      send_word(32'h20000000 + 32'(w));
    end
    send_word(HALT);
    repeat (3) @(posedge clk); #1;
    check("overflow load state", 32'(st), 32'd0);
    check_writes("overflow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
